// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register plus the NZCV flag register and EX-stage branch resolution.
// One-cycle latency ex_* -> mem_*; stall holds all state, flush inserts a bubble and wins over stall.
module ex_mem_stage #(
   parameter int DATA_W = 64,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              ex_valid,
   input  logic [DATA_W-1:0] ex_result,
   input  logic              ex_negative,
   input  logic              ex_zero,
   input  logic              ex_overflow,
   input  logic              ex_carry_out,
   input  logic              ex_set_flags,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic              ex_mem_to_reg,
   input  logic              ex_is_bcond,
   input  logic              ex_is_cbz,
   input  logic              ex_is_cbnz,
   input  logic [3:0]        ex_cond,
   output logic              ex_branch_taken,
   output logic [3:0]        flags_nzcv,
   output logic              mem_valid,
   output logic              mem_reg_write,
   output logic              mem_mem_read,
   output logic              mem_mem_write,
   output logic              mem_mem_to_reg,
   output logic [DATA_W-1:0] mem_result,
   output logic [DATA_W-1:0] mem_store_data,
   output logic [REG_W-1:0]  mem_rd
);

   logic flag_n, flag_z, flag_c, flag_v;
   logic cond_true;
   logic bcond_hit, cbz_hit, cbnz_hit;

   assign flag_n = flags_nzcv[3];
   assign flag_z = flags_nzcv[2];
   assign flag_c = flags_nzcv[1];
   assign flag_v = flags_nzcv[0];

   // Condition uses only committed flags; a setter directly ahead has already written them.
   always_comb begin
      cond_true = 1'b0;
      case (ex_cond)
         4'b0000: cond_true = flag_z;
         4'b0001: cond_true = ~flag_z;
         4'b0010: cond_true = flag_c;
         4'b0011: cond_true = ~flag_c;
         4'b0100: cond_true = flag_n;
         4'b0101: cond_true = ~flag_n;
         4'b0110: cond_true = flag_v;
         4'b0111: cond_true = ~flag_v;
         4'b1000: cond_true = flag_c & ~flag_z;
         4'b1001: cond_true = ~(flag_c & ~flag_z);
         4'b1010: cond_true = (flag_n == flag_v);
         4'b1011: cond_true = (flag_n != flag_v);
         4'b1100: cond_true = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_true = ~(~flag_z & (flag_n == flag_v));
         default: cond_true = 1'b1;
      endcase
   end

   assign bcond_hit       = ex_is_bcond & cond_true;
   assign cbz_hit         = ex_is_cbz & ex_zero;
   assign cbnz_hit        = ex_is_cbnz & ~ex_zero;
   assign ex_branch_taken = ex_valid & ~flush & (bcond_hit | cbz_hit | cbnz_hit);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags_nzcv     <= 4'b0000;
         mem_valid      <= 1'b0;
         mem_reg_write  <= 1'b0;
         mem_mem_read   <= 1'b0;
         mem_mem_write  <= 1'b0;
         mem_mem_to_reg <= 1'b0;
         mem_result     <= '0;
         mem_store_data <= '0;
         mem_rd         <= '0;
      end else if (flush) begin
         mem_valid      <= 1'b0;
         mem_reg_write  <= 1'b0;
         mem_mem_read   <= 1'b0;
         mem_mem_write  <= 1'b0;
         mem_mem_to_reg <= 1'b0;
         mem_result     <= '0;
         mem_store_data <= '0;
         mem_rd         <= '0;
      end else if (!stall) begin
         mem_valid      <= ex_valid;
         mem_reg_write  <= ex_reg_write & ex_valid;
         mem_mem_read   <= ex_mem_read & ex_valid;
         mem_mem_write  <= ex_mem_write & ex_valid;
         mem_mem_to_reg <= ex_mem_to_reg & ex_valid;
         mem_result     <= ex_result;
         mem_store_data <= ex_store_data;
         mem_rd         <= ex_rd;
         if (ex_valid && ex_set_flags)
            flags_nzcv <= {ex_negative, ex_zero, ex_carry_out, ex_overflow};
      end
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed and randomized bench for ex_mem_stage against a behavioural pipeline model.
module tb_ex_mem_stage;

   localparam int DATA_W = 64;
   localparam int REG_W  = 5;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              stall, flush, ex_valid;
   logic [DATA_W-1:0] ex_result, ex_store_data;
   logic              ex_negative, ex_zero, ex_overflow, ex_carry_out, ex_set_flags;
   logic [REG_W-1:0]  ex_rd;
   logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
   logic              ex_is_bcond, ex_is_cbz, ex_is_cbnz;
   logic [3:0]        ex_cond;
   logic              ex_branch_taken;
   logic [3:0]        flags_nzcv;
   logic              mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
   logic [DATA_W-1:0] mem_result, mem_store_data;
   logic [REG_W-1:0]  mem_rd;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic              m_valid;
   logic [3:0]        m_ctrl;
   logic [DATA_W-1:0] m_result, m_store;
   logic [REG_W-1:0]  m_rd;
   logic              m_n, m_z, m_c, m_v;

   always #5 clk = ~clk;

   ex_mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
      .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_result(ex_result),
      .ex_negative(ex_negative), .ex_zero(ex_zero), .ex_overflow(ex_overflow),
      .ex_carry_out(ex_carry_out), .ex_set_flags(ex_set_flags),
      .ex_store_data(ex_store_data), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_is_bcond(ex_is_bcond), .ex_is_cbz(ex_is_cbz), .ex_is_cbnz(ex_is_cbnz),
      .ex_cond(ex_cond), .ex_branch_taken(ex_branch_taken), .flags_nzcv(flags_nzcv),
      .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
      .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
      .mem_result(mem_result), .mem_store_data(mem_store_data), .mem_rd(mem_rd)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Condition truth written from the architectural meaning: even codes test a predicate,
   // odd codes test its inverse, and the last pair always passes.
   function automatic bit model_cond(input int code, input bit n, input bit z, input bit c, input bit v);
      bit base;
      int group = code / 2;
      if (group == 7) return 1'b1;
      if (group == 0)      base = z;
      else if (group == 1) base = c;
      else if (group == 2) base = n;
      else if (group == 3) base = v;
      else if (group == 4) base = c && !z;
      else if (group == 5) base = (n == v);
      else                 base = !z && (n == v);
      return (code % 2 == 1) ? !base : base;
   endfunction

   function automatic bit model_taken();
      bit hit = 1'b0;
      if (ex_is_bcond && model_cond(int'(ex_cond), m_n, m_z, m_c, m_v)) hit = 1'b1;
      if (ex_is_cbz && ex_zero) hit = 1'b1;
      if (ex_is_cbnz && !ex_zero) hit = 1'b1;
      return ex_valid && !flush && hit;
   endfunction

   task automatic model_clear();
      m_valid = 0; m_ctrl = 0; m_result = 0; m_store = 0; m_rd = 0;
      m_n = 0; m_z = 0; m_c = 0; m_v = 0;
   endtask

   task automatic model_edge();
      if (flush) begin
         m_valid = 0; m_ctrl = 0; m_result = 0; m_store = 0; m_rd = 0;
      end else if (!stall) begin
         m_valid  = ex_valid;
         m_ctrl   = ex_valid ? {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} : 4'b0;
         m_result = ex_result;
         m_store  = ex_store_data;
         m_rd     = ex_rd;
         if (ex_valid && ex_set_flags) begin
            m_n = ex_negative; m_z = ex_zero; m_c = ex_carry_out; m_v = ex_overflow;
         end
      end
   endtask

   task automatic compare_state(input string tag);
      check({tag, ".valid"}, mem_valid, m_valid);
      check({tag, ".ctrl"}, {mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg}, m_ctrl);
      check({tag, ".result"}, mem_result, m_result);
      check({tag, ".store"}, mem_store_data, m_store);
      check({tag, ".rd"}, mem_rd, m_rd);
      check({tag, ".flags"}, flags_nzcv, {m_n, m_z, m_c, m_v});
   endtask

   task automatic check_taken(input string tag);
      #1;
      check(tag, ex_branch_taken, model_taken());
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      compare_state(tag);
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      stall = 0; flush = 0; ex_valid = 0; ex_result = 0; ex_store_data = 0;
      ex_negative = 0; ex_zero = 0; ex_overflow = 0; ex_carry_out = 0; ex_set_flags = 0;
      ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0;
      ex_is_bcond = 0; ex_is_cbz = 0; ex_is_cbnz = 0; ex_cond = 0;
   endtask

   task automatic rand_inputs();
      ex_valid      = ($urandom_range(0, 3) != 0);
      ex_result     = {$urandom, $urandom};
      ex_store_data = {$urandom, $urandom};
      {ex_negative, ex_zero, ex_overflow, ex_carry_out} = 4'($urandom);
      ex_set_flags  = $urandom_range(0, 1);
      ex_rd         = 5'($urandom);
      {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} = 4'($urandom);
      {ex_is_bcond, ex_is_cbz, ex_is_cbnz} = 3'($urandom);
      ex_cond       = 4'($urandom);
   endtask

   task automatic set_flags_instr(input bit n, input bit z, input bit c, input bit v);
      clear_inputs();
      ex_valid = 1; ex_set_flags = 1;
      ex_negative = n; ex_zero = z; ex_carry_out = c; ex_overflow = v;
      step("setflags");
      clear_inputs();
      ex_valid = 1; ex_is_bcond = 1;
   endtask

   task automatic bcond_expect(input logic [3:0] cond, input bit exp, input string tag);
      ex_cond = cond;
      #1;
      check(tag, ex_branch_taken, exp);
      check({tag, ".model"}, ex_branch_taken, model_taken());
   endtask

   initial begin
      clear_inputs();
      model_clear();
      reset_n = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1;

      // asynchronous reset with busy inputs, asserted between edges
      rand_inputs();
      ex_valid = 1; ex_set_flags = 1; ex_result = 64'hFFFF_FFFF_FFFF_FFFF;
      {ex_negative, ex_zero, ex_carry_out, ex_overflow} = 4'b1111;
      step("preload");
      check("preload_flags", flags_nzcv, 4'b1111);
      #2 reset_n = 0;
      #1;
      model_clear();
      compare_state("async_reset");
      check("reset_result_zero", mem_result, 64'd0);
      @(negedge clk);
      reset_n = 1;

      // pipeline load
      clear_inputs();
      ex_valid = 1; ex_result = 64'h0123_4567_89AB_CDEF; ex_rd = 5'd9; ex_reg_write = 1;
      step("load");
      check("load_result", mem_result, 64'h0123_4567_89AB_CDEF);
      check("load_rd", mem_rd, 5'd9);
      check("load_regwrite", mem_reg_write, 1'b1);
      check("load_valid", mem_valid, 1'b1);
      ex_valid = 0; ex_mem_write = 1;
      step("invalid");
      check("invalid_regwrite", mem_reg_write, 1'b0);
      check("invalid_memwrite", mem_mem_write, 1'b0);

      // flags and B.cond
      set_flags_instr(0, 1, 1, 0);
      check("subs_flags", flags_nzcv, 4'b0110);
      bcond_expect(4'b0000, 1, "bcond_eq");
      bcond_expect(4'b0001, 0, "bcond_ne");
      bcond_expect(4'b1000, 0, "bcond_hi");
      bcond_expect(4'b1010, 1, "bcond_ge");
      bcond_expect(4'b1111, 1, "bcond_nv");

      // stall holds everything, including flags
      rand_inputs();
      ex_valid = 1; ex_set_flags = 1; stall = 1;
      {ex_negative, ex_zero, ex_carry_out, ex_overflow} = 4'b1001;
      step("stall");
      check("stall_flags", flags_nzcv, 4'b0110);

      // flush beats stall
      ex_is_bcond = 0; ex_is_cbz = 1; ex_zero = 1; ex_is_cbnz = 0;
      flush = 1;
      check_taken("flush_taken");
      check("flush_taken_const", ex_branch_taken, 1'b0);
      step("flush_stall");
      check("flush_valid", mem_valid, 1'b0);
      check("flush_flags", flags_nzcv, 4'b0110);

      // CBZ / CBNZ
      clear_inputs();
      ex_valid = 1; ex_is_cbz = 1; ex_zero = 1;
      #1 check("cbz_z1", ex_branch_taken, 1'b1);
      ex_is_cbz = 0; ex_is_cbnz = 1;
      #1 check("cbnz_z1", ex_branch_taken, 1'b0);
      ex_zero = 0;
      #1 check("cbnz_z0", ex_branch_taken, 1'b1);
      flush = 1;
      #1 check("cbnz_flush", ex_branch_taken, 1'b0);
      flush = 0;
      @(negedge clk);

      // signed conditions
      set_flags_instr(1, 0, 0, 0);
      bcond_expect(4'b1011, 1, "lt_nv10");
      bcond_expect(4'b1010, 0, "ge_nv10");
      bcond_expect(4'b1100, 0, "gt_nv10");
      bcond_expect(4'b1101, 1, "le_nv10");
      set_flags_instr(1, 0, 0, 1);
      bcond_expect(4'b1100, 1, "gt_nv11");
      bcond_expect(4'b1101, 0, "le_nv11");

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         stall = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 6) == 0);
         check_taken("rand_taken");
         step("rand");
         if (i == 200) begin
            stall = 1; flush = 1;
            #2 reset_n = 0;
            #1;
            model_clear();
            compare_state("rand_reset");
            @(negedge clk);
            reset_n = 1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM pipeline stage of the five-stage 64-bit CPU, directly downstream of the execute-stage ALU. It latches the ALU result and the instruction's memory/write-back control into the MEM stage. It also owns the architectural NZCV flag register, updated by flag-setting instructions. It resolves B.cond, CBZ and CBNZ branch decisions in EX from the stored flags and the ALU zero output.

## Interface
Parameters:
- DATA_W, 64, datapath width (result and store data)
- REG_W, 5, register-specifier width

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  hold all registered state this cycle
- flush  in  1  squash the EX instruction: load a bubble and suppress its flag write
- ex_valid  in  1  EX holds a real instruction
- ex_result  in  DATA_W  ALU result
- ex_negative, ex_zero, ex_overflow, ex_carry_out  in  1 each  ALU flags
- ex_set_flags  in  1  instruction writes NZCV (ADDS/SUBS/ANDS)
- ex_store_data  in  DATA_W  forwarded Rt value for STUR
- ex_rd  in  REG_W  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  in  1 each  downstream control
- ex_is_bcond, ex_is_cbz, ex_is_cbnz  in  1 each  branch type
- ex_cond  in  4  B.cond condition field
- ex_branch_taken  out  1  combinational; EX branch resolves taken
- flags_nzcv  out  4  {N,Z,C,V} flag register
- mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  out  1 each  registered
- mem_result, mem_store_data  out  DATA_W  registered
- mem_rd  out  REG_W  registered

## Operation
- Reset (reset_n low, asynchronous): all mem_* outputs 0, flags_nzcv = 4'b0000. This takes effect immediately, independent of clk. On release, the first capture is at the first rising edge with reset_n high.
- Each rising edge, priority is flush > stall > load:
  - flush=1: mem_valid and all mem_ control bits become 0 (bubble). mem_result, mem_store_data and mem_rd become 0. Flags are unchanged. Flush wins even when stall=1.
  - stall=1, flush=0: every register, including flags, holds its value.
  - otherwise: every mem_ field loads its ex_ counterpart. mem_valid = ex_valid. Control bits are ANDed with ex_valid, so an invalid EX never produces a write.
- Flag write: flags_nzcv <= {ex_negative, ex_zero, ex_carry_out, ex_overflow}. This happens only on the load path when ex_valid & ex_set_flags.
- Branch evaluation: ex_branch_taken = ex_valid & ~flush & (bcond_hit | cbz_hit | cbnz_hit).
  - cbz_hit = ex_is_cbz & ex_zero.
  - cbnz_hit = ex_is_cbnz & ~ex_zero. The ALU passes B, so zero reflects Rt.
  - bcond_hit = ex_is_bcond & cond_true(ex_cond, flags_nzcv), using the registered flags only. B.cond never sets flags, so a setter in the preceding instruction has already committed.
- cond_true encodings:
  - 0000 EQ Z; 0001 NE !Z
  - 0010 HS C; 0011 LO !C
  - 0100 MI N; 0101 PL !N
  - 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !(C&!Z)
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE !(!Z&(N==V))
  - 1110 AL 1; 1111 NV 1
- Exactly one of ex_is_bcond/ex_is_cbz/ex_is_cbnz is set per branch. If more than one is set, the result is the OR of the individual hits; no error is flagged.

## Timing
- Latency: ex_* sampled at edge N appear on mem_* after edge N, i.e. one cycle.
- Flags written at edge N are visible on flags_nzcv and to bcond evaluation in cycle N+1. There is no same-cycle bypass.
- ex_branch_taken is purely combinational from current inputs and flags_nzcv; no clock edge is involved.
- Stall released: the next edge loads whatever ex_* presents then. The held instruction is not replayed internally.
- Reset asserted mid-stall or mid-flush clears everything immediately. Stall/flush are ignored while reset_n=0.

## Test plan
- Reset: drive all ex_* nonzero, pulse reset_n low between edges -> mem_* = 0 and flags_nzcv = 0000 immediately, before any edge.
- Pipeline load: ex_valid=1, ex_result=64'h0123_4567_89AB_CDEF, ex_rd=5'd9, ex_reg_write=1 -> after one edge mem_result=64'h0123_4567_89AB_CDEF, mem_rd=9, mem_reg_write=1, mem_valid=1. With ex_valid=0 and reg_write=1 -> mem_reg_write=0.
- Flags + B.cond: SUBS with N=0,Z=1,C=1,V=0, set_flags=1 -> flags_nzcv=4'b0110. Next cycle ex_is_bcond=1: ex_cond=0000 -> taken=1, 0001 -> 0, 1000 (HI) -> 0, 1010 (GE) -> 1.
- Stall/flush priority: stall=1 with new ex_* and set_flags=1 -> mem_* and flags unchanged. Stall=1 with flush=1 -> bubble (mem_valid=0), flags unchanged, ex_branch_taken=0.
- CBZ/CBNZ: ex_is_cbz=1, ex_zero=1 -> taken=1. ex_is_cbnz=1, ex_zero=1 -> taken=0. ex_is_cbnz=1, ex_zero=0 -> taken=1. Same with flush=1 -> taken=0.
- Signed conditions: set flags N=1,V=0,Z=0 -> LT=1, GE=0, GT=0, LE=1. Set N=1,V=1,Z=0 -> GT=1, LE=0.
